exc_ctrl: RTL
=============

Name: exc_ctrl

Overview:
- MEM-stage exception controller, directly upstream of the CP0 register file.
- Each cycle it collects per-instruction exception flags and pending interrupts and picks the highest-priority cause.
- It waits for any outstanding data-memory transaction to drain, then issues a one-cycle commit to CP0 (en, except type, PC, delay-slot flag, bad vaddr).
- It flushes the pipeline and holds a PC redirect (exception vector, or EPC for ERET) until fetch accepts it.

Parameters:
- VEC_BEV1, 32'hBFC0_0380, exception vector when Status.BEV=1
- VEC_BEV0, 32'h8000_0180, exception vector when Status.BEV=0

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- valid_m  in  1  MEM holds a real (non-bubble) instruction
- stall_m  in  1  MEM stalled this cycle
- pc_m  in  32  PC of MEM instruction
- in_delayslot_m  in  1  MEM instruction is in a branch delay slot
- mem_addr_m  in  32  data address of MEM load/store
- adel_if_m, ri_m, sys_m, bp_m, ov_m, adel_ld_m, ades_st_m, eret_m  in  1 each  exception flags carried down the pipe
- mem_busy  in  1  data request outstanding on the bus
- status_i, cause_i, epc_i  in  32 each  current CP0 Status/Cause/EPC
- redirect_ready  in  1  fetch accepts redirect
- cp0_en_o  out  1  commit strobe to CP0
- except_type_o  out  32  EXC_TYPE_* code
- inst_addr_o  out  32  committed PC
- delayslot_o  out  1  committed BD flag
- badvaddr_o  out  32  faulting address
- mem_kill_o  out  1  suppress MEM data write/request
- busy_o  out  1  controller not idle; freeze IF..MEM
- flush_o  out  1  squash IF..MEM
- redirect_valid_o  out  1  redirect request
- redirect_pc_o  out  32  redirect target

Behaviour:
- Reset (rst=0, async): state IDLE; every output and latched field = 0.
- Interrupt condition int_req = status_i[0] & ~status_i[1] & |(cause_i[15:8] & status_i[15:8]).
- Interrupt is taken only on a valid MEM instruction.
- Detection: det = valid_m & ~stall_m & (int_req | any flag), evaluated in IDLE only.
- Priority, highest first: INT > ADEL(fetch) > RI > SYS > BP > OV > ADEL(load) > ADES(store) > ERET.
- badvaddr: pc_m for fetch ADEL; mem_addr_m for load ADEL / store ADES; 0 otherwise.
- Detection latches: type, pc_m, in_delayslot_m, badvaddr.
- mem_kill_o (combinational) = (IDLE & det) | (state != IDLE).
- busy_o = (state != IDLE).
- State IDLE: on det, go to DRAIN if mem_busy, else COMMIT.
- State DRAIN: wait until mem_busy=0, then COMMIT. Can last any length.
- State COMMIT (exactly 1 cycle):
  - cp0_en_o=1; except_type_o, inst_addr_o, delayslot_o, badvaddr_o driven from the latches.
  - flush_o=1, redirect_valid_o=1.
  - redirect_pc_o = epc_i for ERET; otherwise VEC_BEV1 if status_i[22] else VEC_BEV0.
  - redirect_pc_o is captured into a register in this cycle.
  - redirect_ready=1 -> IDLE; else -> REDIRECT.
- State REDIRECT: flush_o=1, redirect_valid_o=1, redirect_pc_o held stable; -> IDLE on redirect_ready.
- Latency: detection with no drain -> commit next cycle; fetch sees redirect in the same cycle as commit.
- cp0_en_o is never high for more than 1 cycle per exception.
- In every cycle outside COMMIT, except_type_o / inst_addr_o / delayslot_o / badvaddr_o = 0.
- No new detection while busy. The pipeline is frozen, so a second exception is impossible and any asserted flags are ignored.
- stall_m=1 blocks detection. The instruction is re-evaluated when the stall drops.
- Exception flags plus eret_m: the exception wins and ERET is discarded.
- Reset mid-DRAIN or mid-REDIRECT: immediate return to IDLE, no commit.

Decomposition:
- The shared defines header holds:
  - EXC_TYPE_INT=32'h1, ADEL=32'h4, ADES=32'h5, SYS=32'h8, BP=32'h9, RI=32'ha, OV=32'hc, ERET=32'he.
  - Status bit positions: IE=0, EXL=1, BEV=22, IM=15:8.
  - Cause IP field: 15:8.
  - State encodings (2-bit).
- One natural sub-module: exc_prio_enc, a combinational priority encoder from flags + int_req to {type, badvaddr_sel}.

Test Plan:
- ri_m=1, pc_m=32'hBFC0_1000, mem_busy=0, BEV=1, redirect_ready=1 -> next cycle cp0_en_o=1, except_type_o=32'ha, redirect_pc_o=32'hBFC0_0380; back to IDLE after 1 cycle.
- ades_st_m=1, mem_addr_m=32'h8000_0003, mem_busy high 3 cycles -> mem_kill_o high from detection; commit exactly 1 cycle after mem_busy falls, badvaddr_o=32'h8000_0003, type 32'h5.
- eret_m=1, epc_i=32'h8000_2000, redirect_ready low 2 cycles -> COMMIT then REDIRECT; redirect_pc_o=32'h8000_2000 held 3 cycles; cp0_en_o high once.
- status_i=32'h0000_0401, cause_i[10]=1, ov_m=1, in_delayslot_m=1 -> type INT (32'h1), delayslot_o=1; repeat with EXL=1 -> type OV (32'hc).
- adel_if_m=1 and sys_m=1 together, pc_m=32'hBFC0_0002 -> type 32'h4, badvaddr_o=32'hBFC0_0002; with stall_m=1 nothing happens until stall drops.
- Assert rst=0 mid-DRAIN -> all outputs 0 asynchronously, no cp0_en_o pulse after release.

Source files
------------

// File: rtl/exc_ctrl_pkg.sv
// Shared definitions for the MEM-stage exception controller.
// Holds exception type codes, CP0 Status/Cause bit positions, FSM state
// encodings, badvaddr source selects and the interrupt-pending helper.
package exc_ctrl_pkg;

  localparam logic [31:0] EXC_TYPE_NONE = 32'h0;
  localparam logic [31:0] EXC_TYPE_INT  = 32'h1;
  localparam logic [31:0] EXC_TYPE_ADEL = 32'h4;
  localparam logic [31:0] EXC_TYPE_ADES = 32'h5;
  localparam logic [31:0] EXC_TYPE_SYS  = 32'h8;
  localparam logic [31:0] EXC_TYPE_BP   = 32'h9;
  localparam logic [31:0] EXC_TYPE_RI   = 32'ha;
  localparam logic [31:0] EXC_TYPE_OV   = 32'hc;
  localparam logic [31:0] EXC_TYPE_ERET = 32'he;

  localparam int unsigned STATUS_IE    = 0;
  localparam int unsigned STATUS_EXL   = 1;
  localparam int unsigned STATUS_BEV   = 22;
  localparam int unsigned STATUS_IM_LO = 8;
  localparam int unsigned STATUS_IM_HI = 15;
  localparam int unsigned CAUSE_IP_LO  = 8;
  localparam int unsigned CAUSE_IP_HI  = 15;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DRAIN    = 2'd1;
  localparam logic [1:0] ST_COMMIT   = 2'd2;
  localparam logic [1:0] ST_REDIRECT = 2'd3;

  localparam logic [1:0] BV_NONE = 2'd0;
  localparam logic [1:0] BV_PC   = 2'd1;
  localparam logic [1:0] BV_MEM  = 2'd2;

  // Interrupts enabled (IE=1, EXL=0) and some unmasked IP bit pending.
  function automatic logic int_pending(input logic [31:0] status,
                                       input logic [31:0] cause);
    return status[STATUS_IE] & ~status[STATUS_EXL] &
           (|(cause[CAUSE_IP_HI:CAUSE_IP_LO] & status[STATUS_IM_HI:STATUS_IM_LO]));
  endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Combinational exception priority encoder.
// Inputs : int_req_i plus per-instruction exception flags.
// Outputs: type_o (EXC_TYPE_* of the winning cause), bv_sel_o (badvaddr
//          source), any_o (some cause present).
module exc_prio_enc
  import exc_ctrl_pkg::*;
(
  input  logic        int_req_i,
  input  logic        adel_if_i,
  input  logic        ri_i,
  input  logic        sys_i,
  input  logic        bp_i,
  input  logic        ov_i,
  input  logic        adel_ld_i,
  input  logic        ades_st_i,
  input  logic        eret_i,
  output logic [31:0] type_o,
  output logic [1:0]  bv_sel_o,
  output logic        any_o
);

  always_comb begin
    type_o   = EXC_TYPE_NONE;
    bv_sel_o = BV_NONE;
    if (int_req_i) begin
      type_o = EXC_TYPE_INT;
    end else if (adel_if_i) begin
      type_o   = EXC_TYPE_ADEL;
      bv_sel_o = BV_PC;
    end else if (ri_i) begin
      type_o = EXC_TYPE_RI;
    end else if (sys_i) begin
      type_o = EXC_TYPE_SYS;
    end else if (bp_i) begin
      type_o = EXC_TYPE_BP;
    end else if (ov_i) begin
      type_o = EXC_TYPE_OV;
    end else if (adel_ld_i) begin
      type_o   = EXC_TYPE_ADEL;
      bv_sel_o = BV_MEM;
    end else if (ades_st_i) begin
      type_o   = EXC_TYPE_ADES;
      bv_sel_o = BV_MEM;
    end else if (eret_i) begin
      type_o = EXC_TYPE_ERET;
    end
  end

  assign any_o = int_req_i | adel_if_i | ri_i | sys_i | bp_i | ov_i |
                 adel_ld_i | ades_st_i | eret_i;

endmodule

// File: rtl/exc_ctrl.sv
// MEM-stage exception controller feeding the CP0 register file.
// Picks the highest-priority exception/interrupt of the MEM instruction,
// waits for outstanding data-memory traffic to drain, issues a one-cycle
// commit to CP0 and holds a PC redirect until fetch accepts it.
// Inputs : clk, rst (async, active-low), MEM instruction info and flags,
//          mem_busy, CP0 Status/Cause/EPC, redirect_ready.
// Outputs: CP0 commit (cp0_en_o, except_type_o, inst_addr_o, delayslot_o,
//          badvaddr_o), pipeline control (mem_kill_o, busy_o, flush_o),
//          redirect_valid_o / redirect_pc_o.
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter logic [31:0] VEC_BEV1 = 32'hBFC0_0380,
  parameter logic [31:0] VEC_BEV0 = 32'h8000_0180
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_m,
  input  logic        stall_m,
  input  logic [31:0] pc_m,
  input  logic        in_delayslot_m,
  input  logic [31:0] mem_addr_m,
  input  logic        adel_if_m,
  input  logic        ri_m,
  input  logic        sys_m,
  input  logic        bp_m,
  input  logic        ov_m,
  input  logic        adel_ld_m,
  input  logic        ades_st_m,
  input  logic        eret_m,
  input  logic        mem_busy,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  input  logic        redirect_ready,
  output logic        cp0_en_o,
  output logic [31:0] except_type_o,
  output logic [31:0] inst_addr_o,
  output logic        delayslot_o,
  output logic [31:0] badvaddr_o,
  output logic        mem_kill_o,
  output logic        busy_o,
  output logic        flush_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o
);

  logic [1:0]  state_q, state_d;
  logic [31:0] type_q, pc_q, bva_q, rpc_q;
  logic        ds_q;

  logic        int_req, det, any_exc;
  logic [31:0] enc_type, bva_d, commit_pc;
  logic [1:0]  bv_sel;

  // Only Status IE/EXL/IM/BEV and Cause IP are consulted.
  logic unused_cp0_bits;
  assign unused_cp0_bits = ^{status_i[31:23], status_i[21:16], status_i[7:2],
                             cause_i[31:16], cause_i[7:0]};

  assign int_req = int_pending(status_i, cause_i) & valid_m;

  exc_prio_enc u_prio (
    .int_req_i (int_req),
    .adel_if_i (adel_if_m),
    .ri_i      (ri_m),
    .sys_i     (sys_m),
    .bp_i      (bp_m),
    .ov_i      (ov_m),
    .adel_ld_i (adel_ld_m),
    .ades_st_i (ades_st_m),
    .eret_i    (eret_m),
    .type_o    (enc_type),
    .bv_sel_o  (bv_sel),
    .any_o     (any_exc)
  );

  assign det = (state_q == ST_IDLE) & valid_m & ~stall_m & any_exc;

  always_comb begin
    bva_d = '0;
    case (bv_sel)
      BV_PC:   bva_d = pc_m;
      BV_MEM:  bva_d = mem_addr_m;
      default: bva_d = '0;
    endcase
  end

  always_comb begin
    if (type_q == EXC_TYPE_ERET) commit_pc = epc_i;
    else if (status_i[STATUS_BEV]) commit_pc = VEC_BEV1;
    else commit_pc = VEC_BEV0;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (det) state_d = mem_busy ? ST_DRAIN : ST_COMMIT;
      ST_DRAIN:    if (!mem_busy) state_d = ST_COMMIT;
      ST_COMMIT:   state_d = redirect_ready ? ST_IDLE : ST_REDIRECT;
      ST_REDIRECT: if (redirect_ready) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      type_q  <= '0;
      pc_q    <= '0;
      ds_q    <= 1'b0;
      bva_q   <= '0;
      rpc_q   <= '0;
    end else begin
      state_q <= state_d;
      if (det) begin
        type_q <= enc_type;
        pc_q   <= pc_m;
        ds_q   <= in_delayslot_m;
        bva_q  <= bva_d;
      end
      // EPC/BEV are sampled at commit; REDIRECT replays this value.
      if (state_q == ST_COMMIT) rpc_q <= commit_pc;
    end
  end

  always_comb begin
    cp0_en_o         = 1'b0;
    except_type_o    = '0;
    inst_addr_o      = '0;
    delayslot_o      = 1'b0;
    badvaddr_o       = '0;
    flush_o          = 1'b0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = '0;
    if (state_q == ST_COMMIT) begin
      cp0_en_o         = 1'b1;
      except_type_o    = type_q;
      inst_addr_o      = pc_q;
      delayslot_o      = ds_q;
      badvaddr_o       = bva_q;
      flush_o          = 1'b1;
      redirect_valid_o = 1'b1;
      redirect_pc_o    = commit_pc;
    end else if (state_q == ST_REDIRECT) begin
      flush_o          = 1'b1;
      redirect_valid_o = 1'b1;
      redirect_pc_o    = rpc_q;
    end
  end

  assign busy_o     = (state_q != ST_IDLE);
  assign mem_kill_o = det | busy_o;

endmodule
